aes_stream_io: RTL and testbench
================================

# aes_stream_io

Byte-serial host front end for the AES-128 core controller. It assembles 16-byte key and data frames from a valid/ready input stream and presents them to the core as 128-bit words. It issues a one-cycle start carrying the key-change and cipher-direction controls, waits for the core's done, and streams the 128-bit result back out byte by byte. It sits between the system bus adapter and the core's `keyChange`/`selCypher` control inputs.

## Interface
- `TIMEOUT_CYC`, default 64: cycles allowed in WAIT before timeout. Used only when the timeout feature is compiled in. Legal range 2..65535.
- `clk` in 1: main clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `s_valid` in 1, `s_ready` out 1: input byte handshake. A byte transfers when both are high.
- `s_data` in 8: input byte.
- `s_kind` in 1: 1 = key frame, 0 = data frame. Sampled on byte 0 only.
- `s_mode` in 1: 1 = encrypt, 0 = decrypt. Sampled on byte 0 of data frames only.
- `core_key` out 128, `core_block` out 128: assembled key and data words, held stable from START until the next frame loads.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_keyChange` out 1, `core_selCypher` out 1: valid while `core_start`=1, 0 otherwise.
- `core_done` in 1: core result-valid pulse.
- `core_result` in 128: core output word, sampled when `core_done`=1 in WAIT.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 8, `m_last` out 1: output byte stream.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky timeout flag.

## Operation
- States: IDLE, LOAD, START, WAIT, DRAIN.
- Reset values:
  - state IDLE, byte counter 0, `core_key`=0, `core_block`=0, key_pending=1.
  - All outputs 0 except `s_ready`=1.
  - The first data frame after reset therefore expands the all-zero key.
- IDLE:
  - `s_ready`=1.
  - On an accepted byte: latch `s_kind` (and `s_mode` if data), store the byte at bits [127:120], counter←1, go to LOAD.
- LOAD:
  - `s_ready`=1.
  - Byte n is written to bits [127-8n -: 8], so byte 0 is the MSB.
  - `s_kind` and `s_mode` are ignored after byte 0.
  - On byte 15, key frame: key register updated, key_pending←1, go to IDLE. No core activity.
  - On byte 15, data frame: go to START.
- START:
  - `s_ready`=0, `core_start`=1 for exactly one cycle.
  - `core_keyChange`=key_pending, `core_selCypher`=latched mode.
  - key_pending←0, go to WAIT.
- WAIT:
  - `s_ready`=0.
  - On `core_done`=1: result→output shift register, counter←0, go to DRAIN.
- DRAIN:
  - `m_valid`=1, `m_data`=shift register bits [127:120].
  - On `m_ready`: shift left 8, counter+1.
  - `m_last`=1 when counter=15; after that handshake go to IDLE.
- Boundary cases:
  - Back-to-back key frames: the last one wins; key_pending stays 1.
  - `core_done` outside WAIT is ignored.
  - `s_valid` with `s_ready`=0 is not consumed; upstream holds the byte.
  - `m_valid` never drops until its byte is accepted.
  - Reset mid-frame or mid-operation: return to reset values; partial frame and in-flight result are discarded.
  - Counter is 4 bits and wraps 15→0 only at frame completion.

## Timing
- `core_start` is asserted in the cycle after the 16th data byte is accepted.
- Byte 0 `m_valid` is asserted the cycle after `core_done` is sampled.
- Throughput: one byte per cycle in LOAD and DRAIN under continuous handshakes.
- Minimum frame-to-frame gap: 16 load + 1 start + core latency + 1 + 16 drain cycles.
- `s_ready` rises in the cycle after the final DRAIN handshake (IDLE).

## Configuration
- Macro: `AES_STREAM_IO_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYC` without `core_done`: `err_timeout`←1, go to IDLE, no output produced, key_pending←1.
  - `err_timeout` clears only on reset.
- Undefined: WAIT lasts indefinitely, `err_timeout` is tied to 0, and the counter is not built.

## Test plan
- FIPS-197 encrypt: key frame 00 01 … 0f, then data frame (mode=1) 00 11 22 … ff.
  - Expect one `core_start` with `core_keyChange`=1 and `core_selCypher`=1.
  - Expect output 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, with `m_last` on byte 16.
- Second data frame (mode=0) carrying 69c4…c55a without a new key frame.
  - Expect `core_keyChange`=0 and output 00112233…eeff.
- Random `s_valid` and `m_ready` gaps (50%) over 20 frames.
  - No byte lost or duplicated.
  - `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Reset low at data byte 7, then a full frame.
  - All outputs return to reset values.
  - The next frame is processed with the all-zero key (`core_keyChange`=1).
- Core model withholds `core_done` for 100 cycles, with the macro defined and `TIMEOUT_CYC`=64.
  - `err_timeout`=1 on WAIT cycle 64, state returns to IDLE, `m_valid` is never asserted.
  - Without the macro, the block stays in WAIT and `busy`=1.
- Stray `core_done` pulse in IDLE and in LOAD.
  - No state change and no `m_valid`.

Source files
------------

// File: rtl/aes_stream_io.sv
// aes_stream_io: byte-serial host front end for the AES-128 core (frame assembly, start, result drain).
// Optional WAIT timeout is compiled in with `define AES_STREAM_IO_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for byte 0 of a key or data frame
// S_LOAD  | collecting bytes 1..15 of the current frame
// S_START | one-cycle start pulse to the core with keyChange/selCypher
// S_WAIT  | waiting for core_done (optionally bounded by TIMEOUT_CYC)
// S_DRAIN | streaming the 16 result bytes out, MSB first
module aes_stream_io #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [7:0]   s_data,
   input  logic         s_kind,
   input  logic         s_mode,
   output logic [127:0] core_key,
   output logic [127:0] core_block,
   output logic         core_start,
   output logic         core_keyChange,
   output logic         core_selCypher,
   input  logic         core_done,
   input  logic [127:0] core_result,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [7:0]   m_data,
   output logic         m_last,
   output logic         busy,
   output logic         err_timeout
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN} state_t;

   state_t        r_state, w_next;
   logic [3:0]    r_cnt;
   logic [127:0]  r_key, r_block, r_out;
   logic          r_kind, r_mode, r_key_pending;
   logic          w_s_fire, w_kind, w_timeout;
   logic [3:0]    w_idx;

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("aes_stream_io: TIMEOUT_CYC out of range 2..65535");
   end

   assign s_ready        = (r_state == S_IDLE) || (r_state == S_LOAD);
   assign m_valid        = (r_state == S_DRAIN);
   assign busy           = (r_state != S_IDLE);
   assign m_data         = r_out[127:120];
   assign core_key       = r_key;
   assign core_block     = r_block;
   assign w_s_fire       = s_valid && s_ready;
   // frame kind and byte index come straight from the bus for byte 0
   assign w_kind         = (r_state == S_IDLE) ? s_kind : r_kind;
   assign w_idx          = (r_state == S_IDLE) ? 4'd0 : r_cnt;

`ifdef AES_STREAM_IO_TIMEOUT_EN
   logic [15:0] r_tcnt;
   logic        r_err;

   assign w_timeout   = (r_state == S_WAIT) && !core_done && (r_tcnt == 16'(TIMEOUT_CYC - 1));
   assign err_timeout = r_err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tcnt <= 16'd0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == S_START)
            r_tcnt <= 16'd0;
         else if (r_state == S_WAIT)
            r_tcnt <= r_tcnt + 16'd1;
         if (w_timeout)
            r_err <= 1'b1;
      end
   end
`else
   assign w_timeout   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_comb begin
      w_next         = r_state;
      core_start     = 1'b0;
      core_keyChange = 1'b0;
      core_selCypher = 1'b0;
      m_last         = 1'b0;
      case (r_state)
         S_IDLE:  if (w_s_fire) w_next = S_LOAD;
         S_LOAD:  if (w_s_fire && r_cnt == 4'd15) w_next = r_kind ? S_IDLE : S_START;
         S_START: begin
            core_start     = 1'b1;
            core_keyChange = r_key_pending;
            core_selCypher = r_mode;
            w_next         = S_WAIT;
         end
         S_WAIT: begin
            if (core_done)      w_next = S_DRAIN;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_DRAIN: begin
            m_last = (r_cnt == 4'd15);
            if (m_ready && r_cnt == 4'd15) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= 4'd0;
         r_key         <= '0;
         r_block       <= '0;
         r_out         <= '0;
         r_kind        <= 1'b0;
         r_mode        <= 1'b0;
         r_key_pending <= 1'b1;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE, S_LOAD: begin
               if (w_s_fire) begin
                  if (r_state == S_IDLE) begin
                     r_kind <= s_kind;
                     if (!s_kind) r_mode <= s_mode;
                  end
                  // byte n lands at bits [127-8n -: 8]
                  if (w_kind) r_key[{~w_idx, 3'b000} +: 8]   <= s_data;
                  else        r_block[{~w_idx, 3'b000} +: 8] <= s_data;
                  r_cnt <= w_idx + 4'd1;
                  if (w_kind && w_idx == 4'd15) r_key_pending <= 1'b1;
               end
            end
            S_START: r_key_pending <= 1'b0;
            S_WAIT: begin
               if (core_done) begin
                  r_out <= core_result;
                  r_cnt <= 4'd0;
               end else if (w_timeout) begin
                  r_key_pending <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (m_ready) begin
                  r_out <= {r_out[119:0], 8'h00};
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_stream_io.sv
// Self-checking bench for aes_stream_io: frame table, random handshake gaps, reset, stray done, timeout.
module tb_aes_stream_io;

   logic         clk = 1'b0;
   logic         reset;
   logic         s_valid, s_ready;
   logic [7:0]   s_data;
   logic         s_kind, s_mode;
   logic [127:0] core_key, core_block;
   logic         core_start, core_keyChange, core_selCypher;
   logic         core_done;
   logic [127:0] core_result;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [7:0]   m_data;
   logic         m_last, busy, err_timeout;

   always #5 clk = ~clk;

   aes_stream_io dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_kind(s_kind), .s_mode(s_mode),
      .core_key(core_key), .core_block(core_block), .core_start(core_start),
      .core_keyChange(core_keyChange), .core_selCypher(core_selCypher),
      .core_done(core_done), .core_result(core_result),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .err_timeout(err_timeout)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   // Stand-in for the AES core: exact on the FIPS-197 vector, a keyed scramble elsewhere.
   function automatic logic [127:0] fake_core(input logic [127:0] k, input logic [127:0] b, input logic enc);
      if (k == K_FIPS && b == P_FIPS && enc)  return C_FIPS;
      if (k == K_FIPS && b == C_FIPS && !enc) return P_FIPS;
      return b ^ {k[63:0], k[127:64]} ^ (enc ? {16{8'h5a}} : {16{8'hc3}});
   endfunction

   logic         md_done = 1'b0, md_done_q = 1'b0, stray_done = 1'b0, withhold = 1'b0;
   int           md_cnt = 0, n_start = 0, bad_ctl = 0;
   logic         st_kc = 1'b0, st_sel = 1'b0, md_sel = 1'b0;
   logic [127:0] md_key = '0, md_blk = '0, md_res = '0;

   assign core_done   = md_done | stray_done;
   assign core_result = md_res;

   always @(negedge clk) begin
      if (!reset) begin
         md_cnt    = 0;
         md_done   = 1'b0;
         md_done_q = 1'b0;
      end else begin
         if (md_done_q) check("m_valid_after_done", 128'(m_valid), 128'd1);
         md_done = 1'b0;
         if (md_cnt > 0) begin
            md_cnt--;
            if (md_cnt == 0) begin
               md_done = 1'b1;
               md_res  = fake_core(md_key, md_blk, md_sel);
            end
         end
         if (core_start) begin
            n_start++;
            st_kc  = core_keyChange;
            st_sel = core_selCypher;
            md_key = core_key;
            md_blk = core_block;
            md_sel = core_selCypher;
            md_cnt = withhold ? 0 : 3;
         end else if (core_keyChange || core_selCypher) begin
            bad_ctl++;
         end
         md_done_q = md_done;
      end
   end

   logic [7:0] rx_q[$];
   logic       rx_last_q[$];
   bit         rand_ready = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int         n_mvalid = 0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("m_hold", 128'({m_valid, m_data}), 128'({1'b1, prev_data}));
         if (m_valid) n_mvalid++;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_valid && m_ready) begin
            rx_q.push_back(m_data);
            rx_last_q.push_back(m_last);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   // Called at a negedge; returns at the negedge after the last byte transferred.
   task automatic send_bytes(input logic k, input logic m, input logic [127:0] d,
                             input int lo, input int hi, input bit gaps);
      for (int i = lo; i <= hi; i++) begin
         int t;
         t = 0;
         if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
         s_valid = 1'b1;
         s_data  = d[8*(15-i) +: 8];
         s_kind  = (i == 0) ? k : ~k;
         s_mode  = (i == 0) ? m : ~m;
         while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (!s_ready) check($sformatf("s_ready_wait byte%0d", i), 128'(s_ready), 128'd1);
         @(negedge clk);
         s_valid = 1'b0;
      end
   endtask

   task automatic wait_result(input string nm, input int s0, input logic exp_kc, input logic exp_sel,
                              input logic [127:0] exp_res);
      int t;
      logic [127:0] got;
      logic [15:0]  lasts;
      t = 0;
      got = '0;
      lasts = '0;
      while (rx_q.size() < 16 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("%s bytes", nm), 128'(rx_q.size()), 128'd16);
      check($sformatf("%s starts", nm), 128'(n_start - s0), 128'd1);
      check($sformatf("%s keyChange", nm), 128'(st_kc), 128'(exp_kc));
      check($sformatf("%s selCypher", nm), 128'(st_sel), 128'(exp_sel));
      for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
         got   = {got[119:0], rx_q[i]};
         lasts = {lasts[14:0], rx_last_q[i]};
      end
      check($sformatf("%s result", nm), got, exp_res);
      check($sformatf("%s m_last", nm), 128'(lasts), 128'h0001);
      rx_q.delete();
      rx_last_q.delete();
   endtask

   typedef struct {
      logic         kind;
      logic         mode;
      logic [127:0] data;
      logic         exp_kc;
      logic [127:0] exp_res;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] k2, k3, blk;
      logic         md;
      int           s0, mv0;

      reset = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_kind = 1'b0; s_mode = 1'b0;
      repeat (3) @(negedge clk);
      check("rst s_ready", 128'(s_ready), 128'd1);
      check("rst busy", 128'(busy), 128'd0);
      check("rst outs", 128'({core_start, core_keyChange, core_selCypher, m_valid, m_last, err_timeout}), 128'd0);
      check("rst core_key", core_key, 128'd0);
      check("rst core_block", core_block, 128'd0);
      reset = 1'b1;
      @(negedge clk);

      k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      k3 = 128'hffeeddccbbaa99887766554433221100;
      vecs[0] = '{1'b1, 1'b0, K_FIPS, 1'b0, '0};
      vecs[1] = '{1'b0, 1'b1, P_FIPS, 1'b1, C_FIPS};
      vecs[2] = '{1'b0, 1'b0, C_FIPS, 1'b0, P_FIPS};
      vecs[3] = '{1'b1, 1'b1, k2, 1'b0, '0};
      vecs[4] = '{1'b1, 1'b0, k3, 1'b0, '0};
      vecs[5] = '{1'b0, 1'b1, 128'h3243f6a8885a308d313198a2e0370734, 1'b1,
                  fake_core(k3, 128'h3243f6a8885a308d313198a2e0370734, 1'b1)};
      vecs[6] = '{1'b0, 1'b0, 128'h0123456789abcdeffedcba9876543210, 1'b0,
                  fake_core(k3, 128'h0123456789abcdeffedcba9876543210, 1'b0)};

      for (int i = 0; i < 7; i++) begin
         s0 = n_start;
         send_bytes(vecs[i].kind, vecs[i].mode, vecs[i].data, 0, 15, 1'b0);
         if (vecs[i].kind) begin
            check($sformatf("vec%0d key idle", i), 128'({busy, s_ready}), 128'b01);
            check($sformatf("vec%0d key no start", i), 128'(n_start - s0), 128'd0);
            check($sformatf("vec%0d core_key", i), core_key, vecs[i].data);
         end else begin
            check($sformatf("vec%0d start timing", i), 128'(core_start), 128'd1);
            wait_result($sformatf("vec%0d", i), s0, vecs[i].exp_kc, vecs[i].mode, vecs[i].exp_res);
         end
      end

      rand_ready = 1'b1;
      for (int f = 0; f < 20; f++) begin
         blk = {$urandom, $urandom, $urandom, $urandom};
         md  = 1'($urandom_range(0, 1));
         s0  = n_start;
         send_bytes(1'b0, md, blk, 0, 15, 1'b1);
         wait_result($sformatf("rnd%0d", f), s0, 1'b0, md, fake_core(k3, blk, md));
      end
      rand_ready = 1'b0;
      repeat (20) @(negedge clk);

      send_bytes(1'b0, 1'b1, P_FIPS, 0, 6, 1'b0);
      s_valid = 1'b1; s_data = P_FIPS[71:64];
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst s_ready/busy", 128'({s_ready, busy}), 128'b10);
      check("midrst outs", 128'({core_start, core_keyChange, core_selCypher, m_valid, m_last, err_timeout}), 128'd0);
      check("midrst core_key", core_key, 128'd0);
      check("midrst core_block", core_block, 128'd0);
      s_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      s0 = n_start;
      send_bytes(1'b0, 1'b1, P_FIPS, 0, 15, 1'b0);
      wait_result("after_rst", s0, 1'b1, 1'b1, fake_core('0, P_FIPS, 1'b1));

      repeat (2) @(negedge clk);
      mv0 = n_mvalid;
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      check("stray idle", 128'({busy, s_ready}), 128'b01);
      blk = 128'h00ff00ff11ee11ee22dd22dd33cc33cc;
      s0 = n_start;
      send_bytes(1'b0, 1'b0, blk, 0, 4, 1'b0);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      check("stray load", 128'({busy, s_ready}), 128'b11);
      check("stray no m_valid", 128'(n_mvalid - mv0), 128'd0);
      send_bytes(1'b0, 1'b0, blk, 5, 15, 1'b0);
      wait_result("stray", s0, 1'b0, 1'b0, fake_core('0, blk, 1'b0));

      repeat (2) @(negedge clk);
      withhold = 1'b1;
      mv0 = n_mvalid;
      s0  = n_start;
      send_bytes(1'b0, 1'b1, blk, 0, 15, 1'b0);
      repeat (100) @(negedge clk);
`ifdef AES_STREAM_IO_TIMEOUT_EN
      check("tmo err", 128'(err_timeout), 128'd1);
      check("tmo idle", 128'({busy, s_ready}), 128'b01);
`else
      check("tmo err tied", 128'(err_timeout), 128'd0);
      check("tmo stuck wait", 128'({busy, s_ready}), 128'b10);
`endif
      check("tmo no m_valid", 128'(n_mvalid - mv0), 128'd0);
      check("tmo one start", 128'(n_start - s0), 128'd1);
      withhold = 1'b0;
`ifndef AES_STREAM_IO_TIMEOUT_EN
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
`endif
      s0 = n_start;
      send_bytes(1'b0, 1'b1, K_FIPS, 0, 15, 1'b0);
      wait_result("post_tmo", s0, 1'b1, 1'b1, fake_core('0, K_FIPS, 1'b1));

      check("ctl outside start", 128'(bad_ctl), 128'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
